// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word fetches, tracks credits, queues words for decode.
// Optional HALT detection is enabled by defining IFU_HALT_DETECT_EN.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                Q_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [15:0]       imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [15:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus1,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam int CW = $clog2(Q_DEPTH + 1);
    localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] deliver_pc;
    logic [15:0]       q_mem [Q_DEPTH];
    logic [PW-1:0]     q_head;
    logic [PW-1:0]     q_tail;
    logic [CW-1:0]     q_count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic              run;
    logic              halted_q;

    logic [CW:0]       credits_used;
    logic              credit_ok;
    logic              req_fire;
    logic              rsp_drop;
    logic              enq;
    logic              deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Q_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Queued words plus in-flight requests may never exceed the queue depth.
    assign credits_used = {1'b0, outstanding} + {1'b0, q_count};
    assign credit_ok    = credits_used < (CW+1)'(Q_DEPTH);

    assign imem_req_valid = run && !redirect_valid && !halted_q && credit_ok;
    assign imem_req_addr  = run ? fetch_pc : '0;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_drop = discard != '0;
    assign enq      = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign deq      = if_valid && if_ready && !redirect_valid;

    assign if_valid    = q_count != '0;
    assign if_instr    = q_mem[q_head];
    assign if_pc       = run ? deliver_pc : '0;
    assign if_pc_plus1 = run ? deliver_pc + ADDR_W'(1) : '0;
    assign halted      = halted_q;

    // Hold outputs quiet until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run <= 1'b0;
        else     run <= 1'b1;
    end

    // Fetch and deliver PCs; a redirect restarts both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            deliver_pc <= RESET_PC;
        end else begin
            unique case (1'b1)
                redirect_valid: begin
                    fetch_pc   <= redirect_pc;
                    deliver_pc <= redirect_pc;
                end
                default: begin
                    if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(1);
                    if (deq)      deliver_pc <= deliver_pc + ADDR_W'(1);
                end
            endcase
        end
    end

    // Credit accounting; stale requests stay counted until they return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid)
                discard <= outstanding - CW'(imem_rsp_valid);
            else if (imem_rsp_valid && rsp_drop)
                discard <= discard - CW'(1);
        end
    end

    // In-order queue pointers and occupancy; flushed on redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else if (redirect_valid) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else begin
            if (enq) q_tail <= ptr_inc(q_tail);
            if (deq) q_head <= ptr_inc(q_head);
            q_count <= q_count + CW'(enq) - CW'(deq);
        end
    end

    // Queue storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Q_DEPTH; i++) q_mem[i] <= '0;
        end else if (enq) begin
            q_mem[q_tail] <= imem_rsp_data;
        end
    end

`ifdef IFU_HALT_DETECT_EN
    logic head_is_halt;
    assign head_is_halt = (q_mem[q_head][15:13] == 3'b111)
                       && (q_mem[q_head][6:0] == 7'd1);

    // Stop issuing once a HALT word leaves the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      halted_q <= 1'b0;
        else if (redirect_valid)      halted_q <= 1'b0;
        else if (deq && head_is_halt) halted_q <= 1'b1;
    end
`else
    assign halted_q = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-configurable memory model plus
// table-driven redirect vectors and hand-written stall/halt sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus1    (if_pc_plus1),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0020) return 16'hE001;
        return {3'b010, a[12:0]};
    endfunction

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [15:0] acc_log[$];
    int          cyc = 0;
    int          lat = 1;

    // Memory: in-order, fixed latency, one response per cycle.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        if (rst) begin
            pend.delete();
        end else begin
            if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{imem_req_addr, cyc + lat});
                acc_log.push_back(imem_req_addr);
            end
        end
        #1;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'h0000;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic collect(input logic [15:0] start, input int n,
                           output logic [15:0] first_instr,
                           output logic [15:0] last_pc,
                           output logic [15:0] last_p1);
        int          got = 0;
        int          budget = 0;
        logic [15:0] exp = start;
        first_instr = '0;
        last_pc     = '0;
        last_p1     = '0;
        if_ready    = 1'b1;
        while (got < n && budget < 200) begin
            if (if_valid) begin
                chk("if_pc", if_pc, exp);
                chk("if_instr", if_instr, mem_word(exp));
                chk("if_pc_plus1", if_pc_plus1, 16'(exp + 16'd1));
                if (got == 0) first_instr = if_instr;
                last_pc = if_pc;
                last_p1 = if_pc_plus1;
                exp = 16'(exp + 16'd1);
                got++;
            end
            step();
            budget++;
        end
        if (got < n) chk("collect_timeout", got, n);
    endtask

    function automatic logic [31:0] acc_at(input int idx);
        if (idx < acc_log.size()) return {16'h0, acc_log[idx]};
        return 32'hDEAD_BEEF;
    endfunction

    typedef struct {
        logic [15:0] pc;
        int          lat;
        int          wait_out;
        logic [15:0] first_instr;
        logic [15:0] last_pc;
        logic [15:0] last_p1;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [15:0] fi, lp, lp1;
        logic [15:0] nxt;
        int          base;
        int          avail;
        int          idx;

        tbl[0] = '{16'h0040, 3, 2, 16'h4040, 16'h0042, 16'h0043};
        tbl[1] = '{16'hFFFE, 1, 0, 16'h5FFE, 16'h0000, 16'h0001};
        tbl[2] = '{16'h1234, 2, 1, 16'h5234, 16'h1236, 16'h1237};
        tbl[3] = '{16'h7FFF, 1, 0, 16'h5FFF, 16'h8001, 16'h8002};

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat            = 1;
        repeat (3) step();

        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_pc_plus1", if_pc_plus1, 0);
        chk("rst_halted", halted, 0);

        rst = 1'b0;
        collect(16'h0000, 6, fi, lp, lp1);
        for (int k = 0; k < 6; k++) chk("seq_req_addr", acc_at(k), k);

        base = 6;
        if_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("stall_credits_le_depth", (acc_log.size() - base) <= 2, 1);
        end
        chk("stall_credits_full", acc_log.size() - base, 2);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_if_valid", if_valid, 1);
        chk("stall_head_pc", if_pc, 16'h0006);
        collect(16'h0006, 4, fi, lp, lp1);

        base = 10;
        imem_req_ready = 1'b0;
        avail = acc_log.size() - base;
        collect(16'(base), avail, fi, lp, lp1);
        nxt = 16'(base + avail);
        for (int k = 0; k < 5; k++) begin
            chk("hold_req_valid", imem_req_valid, 1);
            chk("hold_req_addr", imem_req_addr, nxt);
            chk("hold_no_accept", acc_log.size(), base + avail);
            step();
        end
        idx = acc_log.size();
        imem_req_ready = 1'b1;
        collect(nxt, 3, fi, lp, lp1);
        chk("hold_release_addr", acc_at(idx), nxt);

        foreach (tbl[i]) begin
            int w = 0;
            lat = tbl[i].lat;
            while (pend.size() < tbl[i].wait_out && w < 50) begin
                step();
                w++;
            end
            chk("pending_before_redirect", pend.size() >= tbl[i].wait_out, 1);
            idx = acc_log.size();
            redirect(tbl[i].pc);
            chk("redirect_if_valid", if_valid, 0);
            collect(tbl[i].pc, 3, fi, lp, lp1);
            chk("vec_first_instr", fi, tbl[i].first_instr);
            chk("vec_last_pc", lp, tbl[i].last_pc);
            chk("vec_last_pc_plus1", lp1, tbl[i].last_p1);
            for (int k = 0; k < 3; k++)
                chk("vec_req_addr", acc_at(idx + k), 16'(tbl[i].pc + 16'(k)));
        end

        lat = 1;
        redirect(16'h001E);
        collect(16'h001E, 3, fi, lp, lp1);
        chk("halt_word", lp, 16'h0020);
`ifdef IFU_HALT_DETECT_EN
        idx = acc_log.size();
        for (int k = 0; k < 5; k++) begin
            chk("halted_set", halted, 1);
            chk("halted_no_req", imem_req_valid, 0);
            step();
        end
        chk("halted_no_accept", acc_log.size(), idx);
        redirect(16'h0010);
        chk("halted_cleared", halted, 0);
        collect(16'h0010, 3, fi, lp, lp1);
        chk("resume_last_pc", lp, 16'h0012);
`else
        chk("no_halt_flag", halted, 0);
        collect(16'h0021, 3, fi, lp, lp1);
        chk("no_halt_flag_after", halted, 0);
        chk("no_halt_last_pc", lp, 16'h0023);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
